// File: rtl/bus_terminator_if.sv
// ---------------------------------------------------------------------------
// bus_terminator_if
//
// Groups the CPU-side bus-cycle signals handled by the bus terminator.
//
// Signals:
//   as_n         CPU address strobe, active-low, already synchronised
//   cs           per-device chip selects, active-high, one-hot when valid
//   waitstate    per-device wait from the waitstate generators (1 = not ready)
//   port_size    per-device width code, bits [2i+1:2i]
//   dsack_n      data-transfer acknowledge back to the CPU, active-low
//   berr_n       bus error back to the CPU, active-low
//   cycle_active high while the terminator is working on a cycle
//
// Modports:
//   master  the side that drives the request (CPU, address decoder,
//           waitstate generators) and observes the termination
//   slave   the bus terminator itself
// ---------------------------------------------------------------------------
interface bus_terminator_if #(
    parameter int NUM_DEV = 4
);

    logic                   as_n;
    logic [NUM_DEV-1:0]     cs;
    logic [NUM_DEV-1:0]     waitstate;
    logic [2*NUM_DEV-1:0]   port_size;
    logic [1:0]             dsack_n;
    logic                   berr_n;
    logic                   cycle_active;

    modport master (
        output as_n,
        output cs,
        output waitstate,
        output port_size,
        input  dsack_n,
        input  berr_n,
        input  cycle_active
    );

    modport slave (
        input  as_n,
        input  cs,
        input  waitstate,
        input  port_size,
        output dsack_n,
        output berr_n,
        output cycle_active
    );

endinterface

// File: rtl/bus_terminator.sv
// ---------------------------------------------------------------------------
// bus_terminator
//
// Terminates CPU bus cycles. When the address strobe is seen, the selected
// device and its port width are latched; the cycle is then acknowledged with
// the width-specific dsack_n code once the device reports ready, or ended with
// a bus error if no device answers within TIMEOUT clocks, or immediately if
// more than one chip select is active. The termination is held until the CPU
// releases the address strobe.
//
// Parameters:
//   NUM_DEV   number of decoded devices (1..8)
//   TIMEOUT   WAIT-state clocks before a bus error (1..255)
//
// Ports:
//   clock     system clock, all state changes on its rising edge
//   reset_n   synchronous active-low reset
//   bus       bus_terminator_if slave modport (as_n, cs, waitstate,
//             port_size in; dsack_n, berr_n, cycle_active out)
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module bus_terminator #(
    parameter int         NUM_DEV = 4,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic            clock,
    input  logic            reset_n,
    bus_terminator_if.slave bus
);

    localparam int IDXW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        BERR = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        counter;
    logic [7:0]        counter_next;
    logic [IDXW-1:0]   dev_idx;
    logic [IDXW-1:0]   dev_idx_next;
    logic              dev_valid;
    logic              dev_valid_next;
    logic [1:0]        dev_size;
    logic [1:0]        dev_size_next;

    logic [1:0]        dsack_q;
    logic [1:0]        dsack_next;
    logic              berr_q;
    logic              berr_next;
    logic              active_q;
    logic              active_next;

    logic [3:0]        cs_count;
    logic [IDXW-1:0]   cs_idx;
    logic [1:0]        cs_size;
    logic              dev_ready;

    // Chip-select decode: count the active selects and pick out the index
    // and width of the selected device. Index and width are only meaningful
    // when exactly one select is active.
    always_comb begin
        cs_count = 4'd0;
        cs_idx   = '0;
        cs_size  = 2'b00;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (bus.cs[i]) begin
                cs_count = cs_count + 4'd1;
                cs_idx   = IDXW'(i);
                cs_size  = bus.port_size[2*i +: 2];
            end
        end
    end

    // Ready from the latched device. A cycle with no device latched never
    // becomes ready, so only the timeout can end it. The loop avoids
    // indexing past NUM_DEV when it is not a power of two.
    always_comb begin
        dev_ready = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (dev_valid && (dev_idx == IDXW'(i)) && !bus.waitstate[i]) begin
                dev_ready = 1'b1;
            end
        end
    end

    // Next-state logic. In WAIT the checks run in priority order: strobe
    // release aborts, then ready wins over timeout so a device answering on
    // the last allowed clock is still acknowledged.
    always_comb begin
        state_next     = state;
        counter_next   = counter;
        dev_idx_next   = dev_idx;
        dev_valid_next = dev_valid;
        dev_size_next  = dev_size;

        case (state)
            IDLE: begin
                counter_next = 8'd0;
                if (!bus.as_n) begin
                    if (cs_count == 4'd0) begin
                        state_next     = WAIT;
                        dev_valid_next = 1'b0;
                        dev_idx_next   = '0;
                        dev_size_next  = 2'b00;
                    end else if (cs_count == 4'd1) begin
                        state_next     = WAIT;
                        dev_valid_next = 1'b1;
                        dev_idx_next   = cs_idx;
                        dev_size_next  = cs_size;
                    end else begin
                        state_next     = BERR;
                        dev_valid_next = 1'b0;
                    end
                end
            end

            WAIT: begin
                if (bus.as_n) begin
                    state_next = IDLE;
                end else if (dev_ready) begin
                    state_next = ACK;
                end else if (counter == TIMEOUT) begin
                    state_next = BERR;
                end else begin
                    counter_next = counter + 8'd1;
                end
            end

            ACK: begin
                if (bus.as_n) begin
                    state_next = IDLE;
                end
            end

            BERR: begin
                if (bus.as_n) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output values for the next clock are derived from the next state so
    // the registered outputs line up with the state they describe. ACK is
    // only reached from WAIT, where the latched width is stable.
    always_comb begin
        dsack_next = 2'b11;
        if (state_next == ACK) begin
            case (dev_size)
                2'b00:   dsack_next = 2'b10;
                2'b01:   dsack_next = 2'b01;
                default: dsack_next = 2'b00;
            endcase
        end
        berr_next   = (state_next != BERR);
        active_next = (state_next != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            counter   <= 8'd0;
            dev_idx   <= '0;
            dev_valid <= 1'b0;
            dev_size  <= 2'b00;
            dsack_q   <= 2'b11;
            berr_q    <= 1'b1;
            active_q  <= 1'b0;
        end else begin
            state     <= state_next;
            counter   <= counter_next;
            dev_idx   <= dev_idx_next;
            dev_valid <= dev_valid_next;
            dev_size  <= dev_size_next;
            dsack_q   <= dsack_next;
            berr_q    <= berr_next;
            active_q  <= active_next;
        end
    end

    assign bus.dsack_n      = dsack_q;
    assign bus.berr_n       = berr_q;
    assign bus.cycle_active = active_q;

endmodule

// File: tb/tb_bus_terminator.sv
// ---------------------------------------------------------------------------
// tb_bus_terminator
//
// Directed testbench for bus_terminator. Two instances share clock and reset:
// dut_a uses TIMEOUT=8, dut_b uses TIMEOUT=2 for the ready/timeout tie case.
// Inputs change one time unit after a rising edge; outputs are read at the
// same point, so "after En" means the values registered by edge En.
// ---------------------------------------------------------------------------
module tb_bus_terminator;

    logic clock;
    logic reset_n;

    int checks;
    int errors;

    bus_terminator_if #(.NUM_DEV(4)) bus_a ();
    bus_terminator_if #(.NUM_DEV(4)) bus_b ();

    bus_terminator #(.NUM_DEV(4), .TIMEOUT(8'd8)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    bus_terminator #(.NUM_DEV(4), .TIMEOUT(8'd2)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to one time unit past the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset held for two clocks with an active request, then released while
    // the strobe is still low: the pending cycle starts fresh from IDLE.
    task automatic test_reset();
        reset_n           = 1'b0;
        bus_a.as_n        = 1'b0;
        bus_a.cs          = 4'b0001;
        bus_a.waitstate   = 4'b0000;
        bus_a.port_size   = 8'b0000_0010;
        for (int e = 0; e < 2; e++) begin
            tick();
            checks++;
            if (bus_a.dsack_n !== 2'b11) begin
                errors++;
                $display("[TB] FAIL reset_dsack e%0d got=%b exp=11", e, bus_a.dsack_n);
            end
            checks++;
            if (bus_a.berr_n !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_berr e%0d got=%b exp=1", e, bus_a.berr_n);
            end
            checks++;
            if (bus_a.cycle_active !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_active e%0d got=%b exp=0", e, bus_a.cycle_active);
            end
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (bus_a.cycle_active !== 1'b1 || bus_a.dsack_n !== 2'b11) begin
            errors++;
            $display("[TB] FAIL release_wait active=%b dsack=%b exp active=1 dsack=11",
                     bus_a.cycle_active, bus_a.dsack_n);
        end
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b00) begin
            errors++;
            $display("[TB] FAIL release_ack got=%b exp=00", bus_a.dsack_n);
        end
        bus_a.as_n = 1'b1;
        bus_a.cs   = 4'b0000;
        tick();
        checks++;
        if (bus_a.cycle_active !== 1'b0 || bus_a.dsack_n !== 2'b11) begin
            errors++;
            $display("[TB] FAIL release_idle active=%b dsack=%b exp active=0 dsack=11",
                     bus_a.cycle_active, bus_a.dsack_n);
        end
    endtask

    // Zero-wait 32-bit device 0: ack after E1, held until strobe release at E5.
    task automatic test_zero_wait_32();
        bus_a.cs        = 4'b0001;
        bus_a.port_size = 8'b0000_0010;
        bus_a.waitstate = 4'b1110;
        bus_a.as_n      = 1'b0;
        tick();
        checks++;
        if (bus_a.cycle_active !== 1'b1 || bus_a.dsack_n !== 2'b11) begin
            errors++;
            $display("[TB] FAIL zw_e0 active=%b dsack=%b exp active=1 dsack=11",
                     bus_a.cycle_active, bus_a.dsack_n);
        end
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b00 || bus_a.berr_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zw_e1 dsack=%b berr=%b exp dsack=00 berr=1",
                     bus_a.dsack_n, bus_a.berr_n);
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b00) begin
            errors++;
            $display("[TB] FAIL zw_hold got=%b exp=00", bus_a.dsack_n);
        end
        bus_a.as_n = 1'b1;
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b11 || bus_a.cycle_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zw_e5 dsack=%b active=%b exp dsack=11 active=0",
                     bus_a.dsack_n, bus_a.cycle_active);
        end
    endtask

    // Waited 16-bit device 2, ready from E4. After E0 cs and port_size are
    // swapped to a ready 8-bit device 0; the latched device must be kept.
    task automatic test_waited_16();
        bus_a.cs        = 4'b0100;
        bus_a.port_size = 8'b0001_0000;
        bus_a.waitstate = 4'b0100;
        bus_a.as_n      = 1'b0;
        tick();
        bus_a.cs        = 4'b0001;
        bus_a.port_size = 8'b0000_0000;
        tick();
        tick();
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b11 || bus_a.cycle_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL w16_e3 dsack=%b active=%b exp dsack=11 active=1",
                     bus_a.dsack_n, bus_a.cycle_active);
        end
        bus_a.waitstate = 4'b0000;
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b01 || bus_a.berr_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL w16_e4 dsack=%b berr=%b exp dsack=01 berr=1",
                     bus_a.dsack_n, bus_a.berr_n);
        end
        bus_a.as_n      = 1'b1;
        bus_a.cs        = 4'b0000;
        bus_a.waitstate = 4'b1111;
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b11) begin
            errors++;
            $display("[TB] FAIL w16_release got=%b exp=11", bus_a.dsack_n);
        end
    endtask

    // No device selected with TIMEOUT=8: bus error registered at E9.
    task automatic test_timeout();
        bus_a.cs        = 4'b0000;
        bus_a.waitstate = 4'b0000;
        bus_a.as_n      = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            tick();
        end
        checks++;
        if (bus_a.berr_n !== 1'b1 || bus_a.cycle_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_e8 berr=%b active=%b exp berr=1 active=1",
                     bus_a.berr_n, bus_a.cycle_active);
        end
        tick();
        checks++;
        if (bus_a.berr_n !== 1'b0 || bus_a.dsack_n !== 2'b11) begin
            errors++;
            $display("[TB] FAIL to_e9 berr=%b dsack=%b exp berr=0 dsack=11",
                     bus_a.berr_n, bus_a.dsack_n);
        end
        tick();
        checks++;
        if (bus_a.berr_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_hold got=%b exp=0", bus_a.berr_n);
        end
        bus_a.as_n      = 1'b1;
        bus_a.waitstate = 4'b1111;
        tick();
        checks++;
        if (bus_a.berr_n !== 1'b1 || bus_a.cycle_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_release berr=%b active=%b exp berr=1 active=0",
                     bus_a.berr_n, bus_a.cycle_active);
        end
    endtask

    // Two chip selects at once: bus error on the first edge.
    task automatic test_conflict();
        bus_a.cs        = 4'b0011;
        bus_a.waitstate = 4'b0000;
        bus_a.as_n      = 1'b0;
        tick();
        checks++;
        if (bus_a.berr_n !== 1'b0 || bus_a.dsack_n !== 2'b11 || bus_a.cycle_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conflict berr=%b dsack=%b active=%b exp berr=0 dsack=11 active=1",
                     bus_a.berr_n, bus_a.dsack_n, bus_a.cycle_active);
        end
        bus_a.as_n = 1'b1;
        bus_a.cs   = 4'b0000;
        tick();
        checks++;
        if (bus_a.berr_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conflict_release got=%b exp=1", bus_a.berr_n);
        end
    endtask

    // Strobe released at E2 while still waiting: quiet return to IDLE.
    task automatic test_abort();
        bus_a.cs        = 4'b0001;
        bus_a.port_size = 8'b0000_0010;
        bus_a.waitstate = 4'b1111;
        bus_a.as_n      = 1'b0;
        tick();
        tick();
        bus_a.as_n = 1'b1;
        tick();
        checks++;
        if (bus_a.cycle_active !== 1'b0 || bus_a.dsack_n !== 2'b11 || bus_a.berr_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort active=%b dsack=%b berr=%b exp active=0 dsack=11 berr=1",
                     bus_a.cycle_active, bus_a.dsack_n, bus_a.berr_n);
        end
        bus_a.waitstate = 4'b0000;
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b11 || bus_a.cycle_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_quiet dsack=%b active=%b exp dsack=11 active=0",
                     bus_a.dsack_n, bus_a.cycle_active);
        end
        bus_a.cs        = 4'b0000;
        bus_a.waitstate = 4'b1111;
    endtask

    // 8-bit device 1, then a second cycle on the edge right after IDLE.
    task automatic test_back_to_back();
        bus_a.cs        = 4'b0010;
        bus_a.port_size = 8'b0000_0000;
        bus_a.waitstate = 4'b1101;
        bus_a.as_n      = 1'b0;
        tick();
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_first got=%b exp=10", bus_a.dsack_n);
        end
        bus_a.as_n = 1'b1;
        tick();
        bus_a.as_n = 1'b0;
        tick();
        checks++;
        if (bus_a.cycle_active !== 1'b1 || bus_a.dsack_n !== 2'b11) begin
            errors++;
            $display("[TB] FAIL b2b_restart active=%b dsack=%b exp active=1 dsack=11",
                     bus_a.cycle_active, bus_a.dsack_n);
        end
        tick();
        checks++;
        if (bus_a.dsack_n !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_second got=%b exp=10", bus_a.dsack_n);
        end
        bus_a.as_n      = 1'b1;
        bus_a.cs        = 4'b0000;
        bus_a.waitstate = 4'b1111;
        tick();
    endtask

    // TIMEOUT=2 instance: ready arrives exactly when counter==2 (E3), size
    // code 11 acks as 32-bit. Then reset during ACK drops dsack_n.
    task automatic test_tie_and_reset();
        bus_b.cs        = 4'b0001;
        bus_b.port_size = 8'b0000_0011;
        bus_b.waitstate = 4'b1111;
        bus_b.as_n      = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus_b.dsack_n !== 2'b11 || bus_b.berr_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tie_e2 dsack=%b berr=%b exp dsack=11 berr=1",
                     bus_b.dsack_n, bus_b.berr_n);
        end
        bus_b.waitstate = 4'b1110;
        tick();
        checks++;
        if (bus_b.dsack_n !== 2'b00 || bus_b.berr_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tie_e3 dsack=%b berr=%b exp dsack=00 berr=1",
                     bus_b.dsack_n, bus_b.berr_n);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (bus_b.dsack_n !== 2'b11 || bus_b.cycle_active !== 1'b0 || bus_b.berr_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset dsack=%b active=%b berr=%b exp dsack=11 active=0 berr=1",
                     bus_b.dsack_n, bus_b.cycle_active, bus_b.berr_n);
        end
        bus_b.as_n = 1'b1;
        reset_n    = 1'b1;
        tick();
        checks++;
        if (bus_b.cycle_active !== 1'b0 || bus_b.dsack_n !== 2'b11) begin
            errors++;
            $display("[TB] FAIL post_reset_idle active=%b dsack=%b exp active=0 dsack=11",
                     bus_b.cycle_active, bus_b.dsack_n);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset_n         = 1'b0;
        bus_a.as_n      = 1'b1;
        bus_a.cs        = 4'b0000;
        bus_a.waitstate = 4'b1111;
        bus_a.port_size = 8'h00;
        bus_b.as_n      = 1'b1;
        bus_b.cs        = 4'b0000;
        bus_b.waitstate = 4'b1111;
        bus_b.port_size = 8'h00;

        $display("[TB] starting bus_terminator tests");
        test_reset();
        test_zero_wait_32();
        test_waited_16();
        test_timeout();
        test_conflict();
        test_abort();
        test_back_to_back();
        test_tie_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_terminator.md
BUS_TERMINATOR -- requirements
Module: bus_terminator

Interface
REQ-001 Parameter NUM_DEV, default 4, number of decoded devices (1..8).
REQ-002 Parameter TIMEOUT, default 8'd255, WAIT-state clocks before bus error (1..255).
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset; synchronous, active-low.
REQ-005 as_n  input  1  CPU address strobe, active-low, already synchronised to clock.
REQ-006 cs  input  NUM_DEV  per-device chip selects, active-high, one-hot when valid.
REQ-007 waitstate  input  NUM_DEV  per-device wait from the waitstate generators; 1 = not ready, 0 = ready.
REQ-008 port_size  input  2*NUM_DEV  per-device width, bits [2i+1:2i]: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = treated as 32-bit.
REQ-009 dsack_n  output  2  CPU data-transfer acknowledge, active-low, registered.
REQ-010 berr_n  output  1  CPU bus error, active-low, registered.
REQ-011 cycle_active  output  1  high while state is not IDLE, registered.

Function
REQ-012 The FSM SHALL have four states: IDLE, WAIT, ACK, BERR.
REQ-013 IDLE: as_n=0 with exactly one cs bit set -> WAIT; latch device index and its port_size; clear 8-bit counter to 0.
REQ-014 IDLE: as_n=0 with cs all zero -> WAIT with no device latched; waitstate is ignored, so only timeout ends the cycle.
REQ-015 IDLE: as_n=0 with two or more cs bits set -> BERR on the same edge.
REQ-016 WAIT, per edge, in priority order: as_n=1 -> IDLE (aborted, no dsack/berr); waitstate[idx]=0 -> ACK; counter==TIMEOUT -> BERR; else counter+1.
REQ-017 Ready and timeout true on the same edge SHALL resolve to ACK.
REQ-018 cs and port_size changes after the IDLE->WAIT edge SHALL be ignored until the next IDLE.
REQ-019 On entering ACK, dsack_n SHALL take the latched-size code: 8-bit 2'b10, 16-bit 2'b01, 32-bit or 11 2'b00.
REQ-020 ACK: dsack_n SHALL hold until as_n=1 is sampled; that edge -> IDLE and dsack_n=2'b11.
REQ-021 BERR: berr_n=0 and dsack_n=2'b11 SHALL hold until as_n=1 is sampled; that edge -> IDLE and berr_n=1.
REQ-022 dsack_n and berr_n SHALL never be asserted in the same cycle.
REQ-023 Minimum latency: as_n low sampled at edge E0 and ready at E1 -> dsack_n asserted after E1.
REQ-024 Back-to-back cycles: as_n low again on the edge after returning to IDLE SHALL start a new cycle normally.
REQ-025 All outputs SHALL be driven from flops; no combinational input-to-output path.

Reset
REQ-026 reset_n=0 at an edge SHALL force IDLE, counter=0, dsack_n=2'b11, berr_n=1, cycle_active=0, overriding all other inputs.
REQ-027 Reset asserted mid-WAIT, ACK or BERR SHALL abort immediately; after release the block SHALL wait in IDLE for the next as_n=0.
REQ-028 A cycle already in progress when reset releases (as_n low) SHALL be treated as new; it is evaluated from IDLE on the next edge.

Verification
REQ-029 Reset: reset_n=0 for 2 clocks with as_n=0, cs=0001, waitstate=0 -> dsack_n=11, berr_n=1, cycle_active=0 throughout.
REQ-030 Zero-wait 32-bit: cs=0001, port_size[1:0]=10, waitstate[0]=0, as_n low at E0 -> dsack_n=00 after E1; as_n high at E5 -> dsack_n=11 after E5.
REQ-031 Waited 16-bit: cs=0100, port_size[5:4]=01, waitstate[2] high until E3, low from E4 -> dsack_n=01 after E4, berr_n=1.
REQ-032 Timeout: TIMEOUT=8, cs=0000, as_n low at E0 -> berr_n=0 after E9, dsack_n=11; as_n high -> berr_n=1 one edge later.
REQ-033 Conflict and abort: cs=0011 at E0 -> berr_n=0 after E0; separately, as_n high at E2 during WAIT -> IDLE, no dsack/berr.
REQ-034 Tie and mid-reset: TIMEOUT=2, waitstate[0] falls exactly at counter==2 -> dsack_n asserted, berr_n=1; reset_n=0 during ACK -> dsack_n=11 after that edge.
